// File: rtl/hazard_controller_pkg.sv
// Shared types, encodings and the main/ALU decoders for the RV32I hazard-aware control path.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // alu_ctl: 00 add, 01 sub (branch compare), 10 from funct3/funct7, 11 pass immediate
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_ctl;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

    function automatic ctrl_t main_decode(input logic [6:0] opcode);
        ctrl_t c;
        c          = '0;
        c.uses_rs1 = 1'b1;
        case (opcode)
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.alu_src_b  = 1'b1;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.imm_src   = IMM_S;
                c.uses_rs2  = 1'b1;
            end
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_ctl   = 2'b10;
                c.uses_rs2  = 1'b1;
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.alu_ctl   = 2'b10;
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.imm_src  = IMM_B;
                c.alu_ctl  = 2'b01;
                c.uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
                c.imm_src    = IMM_J;
                c.uses_rs1   = 1'b0;
            end
            OP_JALR: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
                c.alu_src_b  = 1'b1;
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_ctl   = 2'b11;
                c.uses_rs1  = 1'b0;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.imm_src   = IMM_U;
                c.uses_rs1  = 1'b0;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic alu_op_t alu_decode(input logic [1:0] alu_ctl, input logic [2:0] funct3,
                                           input logic funct7b5, input logic opb5);
        alu_op_t op;
        op = ALU_ADD;
        unique case (alu_ctl)
            2'b00: op = ALU_ADD;
            2'b01: op = ALU_SUB;
            2'b11: op = ALU_PASSB;
            2'b10: begin
                unique case (funct3)
                    3'b000: op = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                    3'b001: op = ALU_SLL;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b101: op = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Control bus between the datapath (master) and hazard_controller (slave).
interface hazard_controller_if
    import hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      instr_d;
    logic             zero_e;
    logic             lt_e;
    logic             ltu_e;
    logic [2:0]       imm_src_d;
    logic             alu_src_a_e;
    logic             alu_src_b_e;
    alu_op_t          alu_op_e;
    logic [1:0]       result_src_e;
    logic [1:0]       result_src_w;
    logic             mem_write_m;
    logic [2:0]       funct3_m;
    logic             reg_write_m;
    logic             reg_write_w;
    logic             pc_src_e;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    fwd_sel_t         fwd_a_e;
    fwd_sel_t         fwd_b_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output instr_d, zero_e, lt_e, ltu_e,
        input  imm_src_d, alu_src_a_e, alu_src_b_e, alu_op_e, result_src_e, result_src_w,
        input  mem_write_m, funct3_m, reg_write_m, reg_write_w, pc_src_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_d, zero_e, lt_e, ltu_e,
        output imm_src_d, alu_src_a_e, alu_src_b_e, alu_op_e, result_src_e, result_src_w,
        output mem_write_m, funct3_m, reg_write_m, reg_write_w, pc_src_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller_hazard_unit.sv
// Combinational hazard detection: forwarding selects, load-use/interlock stalls, branch flushes.
module hazard_unit
    import hazard_controller_pkg::*;
#(
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs1_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_d,
    input  logic                  i_uses_rs1_d,
    input  logic                  i_uses_rs2_d,
    input  logic [REG_ADDR_W-1:0] i_rs1_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_e,
    input  logic [REG_ADDR_W-1:0] i_rd_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_e,
    input  logic                  i_reg_write_m,
    input  logic                  i_reg_write_w,
    input  logic [1:0]            i_result_src_e,
    input  logic                  i_pc_src_e,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output fwd_sel_t              o_fwd_a_e,
    output fwd_sel_t              o_fwd_b_e
);

    logic w_dep_e;
    logic w_dep_m;
    logic w_load_use;
    logic w_interlock;
    logic w_hazard;

    function automatic fwd_sel_t fwd_pick(input logic [REG_ADDR_W-1:0] rs,
                                          input logic [REG_ADDR_W-1:0] rd_m,
                                          input logic wr_m,
                                          input logic [REG_ADDR_W-1:0] rd_w,
                                          input logic wr_w);
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    always_comb begin
        o_fwd_a_e = FWD_NONE;
        o_fwd_b_e = FWD_NONE;
        if (FWD_EN) begin
            o_fwd_a_e = fwd_pick(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
            o_fwd_b_e = fwd_pick(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
        end
    end

    // Does a source operand used in Decode name the destination of E or M?
    assign w_dep_e = (i_rd_e != '0) && ((i_uses_rs1_d && (i_rs1_d == i_rd_e)) ||
                                        (i_uses_rs2_d && (i_rs2_d == i_rd_e)));
    assign w_dep_m = (i_rd_m != '0) && ((i_uses_rs1_d && (i_rs1_d == i_rd_m)) ||
                                        (i_uses_rs2_d && (i_rs2_d == i_rd_m)));

    assign w_load_use  = w_dep_e && (i_result_src_e == RES_MEM);
    assign w_interlock = (w_dep_e && i_reg_write_e) || (w_dep_m && i_reg_write_m);
    assign w_hazard    = FWD_EN ? w_load_use : w_interlock;

    // A taken branch discards the stalled instruction anyway, so the flush wins.
    assign o_stall_f = w_hazard && !i_pc_src_e;
    assign o_stall_d = w_hazard && !i_pc_src_e;
    assign o_flush_d = i_pc_src_e;
    assign o_flush_e = w_hazard || i_pc_src_e;

endmodule

// File: rtl/hazard_controller.sv
// Pipelined RV32I control path with built-in forwarding, stall/flush generation and counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave bus
);

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        alu_op_t               alu_op;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } de_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
    } em_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } mw_t;

    ctrl_t                 w_ctrl_d;
    de_t                   w_de_d;
    de_t                   r_de;
    em_t                   r_em;
    mw_t                   r_mw;
    logic [REG_ADDR_W-1:0] w_rs1_d;
    logic [REG_ADDR_W-1:0] w_rs2_d;
    logic                  w_cond;
    logic                  w_pc_src_e;
    logic                  w_stall_d;
    logic                  w_flush_e;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic                  w_unused;

    assign w_ctrl_d = main_decode(bus.instr_d[6:0]);
    assign w_rs1_d  = bus.instr_d[15 +: REG_ADDR_W];
    assign w_rs2_d  = bus.instr_d[20 +: REG_ADDR_W];
    assign w_unused = ^{bus.instr_d[31], bus.instr_d[29:25]};

    always_comb begin
        w_de_d            = '0;
        w_de_d.reg_write  = w_ctrl_d.reg_write;
        w_de_d.result_src = w_ctrl_d.result_src;
        w_de_d.mem_write  = w_ctrl_d.mem_write;
        w_de_d.jump       = w_ctrl_d.jump;
        w_de_d.branch     = w_ctrl_d.branch;
        w_de_d.alu_op     = alu_decode(w_ctrl_d.alu_ctl, bus.instr_d[14:12], bus.instr_d[30],
                                       bus.instr_d[5]);
        w_de_d.alu_src_a  = w_ctrl_d.alu_src_a;
        w_de_d.alu_src_b  = w_ctrl_d.alu_src_b;
        w_de_d.funct3     = bus.instr_d[14:12];
        w_de_d.rd         = bus.instr_d[7 +: REG_ADDR_W];
        w_de_d.rs1        = w_rs1_d;
        w_de_d.rs2        = w_rs2_d;
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_de.funct3)
            BR_EQ:   w_cond = bus.zero_e;
            BR_NE:   w_cond = !bus.zero_e;
            BR_LT:   w_cond = bus.lt_e;
            BR_GE:   w_cond = !bus.lt_e;
            BR_LTU:  w_cond = bus.ltu_e;
            BR_GEU:  w_cond = !bus.ltu_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_pc_src_e = r_de.jump || (r_de.branch && w_cond);

    hazard_unit #(
        .FWD_EN     (FWD_EN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_unit (
        .i_rs1_d        (w_rs1_d),
        .i_rs2_d        (w_rs2_d),
        .i_uses_rs1_d   (w_ctrl_d.uses_rs1),
        .i_uses_rs2_d   (w_ctrl_d.uses_rs2),
        .i_rs1_e        (r_de.rs1),
        .i_rs2_e        (r_de.rs2),
        .i_rd_e         (r_de.rd),
        .i_rd_m         (r_em.rd),
        .i_rd_w         (r_mw.rd),
        .i_reg_write_e  (r_de.reg_write),
        .i_reg_write_m  (r_em.reg_write),
        .i_reg_write_w  (r_mw.reg_write),
        .i_result_src_e (r_de.result_src),
        .i_pc_src_e     (w_pc_src_e),
        .o_stall_f      (bus.stall_f),
        .o_stall_d      (w_stall_d),
        .o_flush_d      (bus.flush_d),
        .o_flush_e      (w_flush_e),
        .o_fwd_a_e      (bus.fwd_a_e),
        .o_fwd_b_e      (bus.fwd_b_e)
    );

    // Bubbles are all-zero so no stale result_src can fake a later load-use hazard.
    always_ff @(posedge clk) begin
        if (rst || w_flush_e) begin
            r_de <= '0;
        end else begin
            r_de <= w_de_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_em <= '0;
            r_mw <= '0;
        end else begin
            r_em.reg_write  <= r_de.reg_write;
            r_em.result_src <= r_de.result_src;
            r_em.mem_write  <= r_de.mem_write;
            r_em.funct3     <= r_de.funct3;
            r_em.rd         <= r_de.rd;
            r_mw.reg_write  <= r_em.reg_write;
            r_mw.result_src <= r_em.result_src;
            r_mw.rd         <= r_em.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_d) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_pc_src_e) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.imm_src_d    = w_ctrl_d.imm_src;
    assign bus.alu_src_a_e  = r_de.alu_src_a;
    assign bus.alu_src_b_e  = r_de.alu_src_b;
    assign bus.alu_op_e     = r_de.alu_op;
    assign bus.result_src_e = r_de.result_src;
    assign bus.result_src_w = r_mw.result_src;
    assign bus.mem_write_m  = r_em.mem_write;
    assign bus.funct3_m     = r_em.funct3;
    assign bus.reg_write_m  = r_em.reg_write;
    assign bus.reg_write_w  = r_mw.reg_write;
    assign bus.pc_src_e     = w_pc_src_e;
    assign bus.stall_d      = w_stall_d;
    assign bus.flush_e      = w_flush_e;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: one forwarding DUT and one interlock-only DUT driven cycle by cycle.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    hazard_controller_if #(.CNT_W(16)) bus_f ();
    hazard_controller_if #(.CNT_W(16)) bus_i ();

    hazard_controller #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f.slave)
    );

    hazard_controller #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) dut_i (
        .clk (clk),
        .rst (rst),
        .bus (bus_i.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] b_ins(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, 5'b01000, 7'b1100011};
    endfunction

    function automatic logic [31:0] add_x(input logic [4:0] rd, input logic [4:0] a,
                                          input logic [4:0] b);
        return r_ins(7'b0000000, b, a, 3'b000, rd);
    endfunction

    function automatic logic [31:0] sub_x(input logic [4:0] rd, input logic [4:0] a,
                                          input logic [4:0] b);
        return r_ins(7'b0100000, b, a, 3'b000, rd);
    endfunction

    function automatic logic [31:0] lw_x(input logic [4:0] rd);
        return i_ins(12'd0, 5'd0, 3'b010, rd, 7'b0000011);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_f(input logic [31:0] ins);
        bus_f.instr_d = ins;
        #1;
    endtask

    task automatic drv_i(input logic [31:0] ins);
        bus_i.instr_d = ins;
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus_f.instr_d = NOP;
        bus_i.instr_d = NOP;
        bus_f.zero_e  = 1'b0;
        bus_f.lt_e    = 1'b0;
        bus_f.ltu_e   = 1'b0;
        bus_i.zero_e  = 1'b0;
        bus_i.lt_e    = 1'b0;
        bus_i.ltu_e   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (bus_f.reg_write_m !== 1'b0) begin n_bad++;
            $display("FAIL rst_reg_write_m got=%0h want=0", bus_f.reg_write_m); end
        n_total++; if (bus_f.reg_write_w !== 1'b0) begin n_bad++;
            $display("FAIL rst_reg_write_w got=%0h want=0", bus_f.reg_write_w); end
        n_total++; if (bus_f.mem_write_m !== 1'b0) begin n_bad++;
            $display("FAIL rst_mem_write_m got=%0h want=0", bus_f.mem_write_m); end
        n_total++; if (bus_f.result_src_e !== 2'b00) begin n_bad++;
            $display("FAIL rst_result_src_e got=%0h want=0", bus_f.result_src_e); end
        n_total++; if (bus_f.pc_src_e !== 1'b0 || bus_f.stall_d !== 1'b0 ||
                       bus_f.flush_e !== 1'b0) begin n_bad++;
            $display("FAIL rst_ctl got=%0h%0h%0h want=000", bus_f.pc_src_e, bus_f.stall_d,
                     bus_f.flush_e); end
        n_total++; if (bus_f.fwd_a_e !== FWD_NONE || bus_f.fwd_b_e !== FWD_NONE) begin n_bad++;
            $display("FAIL rst_fwd got=%0h/%0h want=0/0", bus_f.fwd_a_e, bus_f.fwd_b_e); end
        n_total++; if (bus_f.stall_cnt !== 16'd0 || bus_f.flush_cnt !== 16'd0) begin n_bad++;
            $display("FAIL rst_cnt got=%0h/%0h want=0/0", bus_f.stall_cnt, bus_f.flush_cnt); end
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drv_f(add_x(5'd5, 5'd1, 5'd2));
        step();
        drv_f(sub_x(5'd6, 5'd5, 5'd3));
        n_total++; if (bus_f.stall_d !== 1'b0) begin n_bad++;
            $display("FAIL fwdm_stall got=%0h want=0", bus_f.stall_d); end
        step();
        drv_f(NOP);
        n_total++; if (bus_f.fwd_a_e !== FWD_MEM) begin n_bad++;
            $display("FAIL fwdm_a got=%0h want=2", bus_f.fwd_a_e); end
        n_total++; if (bus_f.fwd_b_e !== FWD_NONE) begin n_bad++;
            $display("FAIL fwdm_b got=%0h want=0", bus_f.fwd_b_e); end
        n_total++; if (bus_f.alu_op_e !== ALU_SUB || bus_f.reg_write_m !== 1'b1) begin n_bad++;
            $display("FAIL fwdm_pipe got=%0h/%0h want=1/1", bus_f.alu_op_e, bus_f.reg_write_m); end
    endtask

    task automatic test_fwd_wb();
        do_reset();
        drv_f(add_x(5'd5, 5'd1, 5'd2));
        step();
        drv_f(NOP);
        step();
        drv_f(sub_x(5'd6, 5'd5, 5'd3));
        step();
        drv_f(NOP);
        n_total++; if (bus_f.fwd_a_e !== FWD_WB) begin n_bad++;
            $display("FAIL fwdw_a got=%0h want=1", bus_f.fwd_a_e); end
        n_total++; if (bus_f.reg_write_w !== 1'b1 || bus_f.result_src_w !== RES_ALU) begin n_bad++;
            $display("FAIL fwdw_wb got=%0h/%0h want=1/0", bus_f.reg_write_w, bus_f.result_src_w); end
    endtask

    task automatic test_load_use();
        do_reset();
        drv_f(lw_x(5'd5));
        n_total++; if (bus_f.imm_src_d !== IMM_I) begin n_bad++;
            $display("FAIL lu_imm got=%0h want=0", bus_f.imm_src_d); end
        step();
        drv_f(add_x(5'd6, 5'd5, 5'd5));
        n_total++; if ({bus_f.stall_f, bus_f.stall_d, bus_f.flush_e, bus_f.flush_d} !== 4'b1110)
            begin n_bad++;
            $display("FAIL lu_stall got=%0b want=1110",
                     {bus_f.stall_f, bus_f.stall_d, bus_f.flush_e, bus_f.flush_d}); end
        step();
        drv_f(add_x(5'd6, 5'd5, 5'd5));
        n_total++; if (bus_f.stall_d !== 1'b0 || bus_f.result_src_e !== 2'b00) begin n_bad++;
            $display("FAIL lu_release got=%0h/%0h want=0/0", bus_f.stall_d,
                     bus_f.result_src_e); end
        n_total++; if (bus_f.stall_cnt !== 16'd1) begin n_bad++;
            $display("FAIL lu_cnt got=%0d want=1", bus_f.stall_cnt); end
        step();
        drv_f(NOP);
        n_total++; if (bus_f.fwd_a_e !== FWD_WB || bus_f.fwd_b_e !== FWD_WB) begin n_bad++;
            $display("FAIL lu_fwd got=%0h/%0h want=1/1", bus_f.fwd_a_e, bus_f.fwd_b_e); end
        n_total++; if (bus_f.result_src_w !== RES_MEM || bus_f.stall_cnt !== 16'd1) begin n_bad++;
            $display("FAIL lu_wb got=%0h/%0d want=1/1", bus_f.result_src_w, bus_f.stall_cnt); end
    endtask

    task automatic test_interlock();
        do_reset();
        drv_i(add_x(5'd5, 5'd1, 5'd2));
        step();
        drv_i(sub_x(5'd6, 5'd5, 5'd3));
        n_total++; if (bus_i.stall_d !== 1'b1 || bus_i.stall_f !== 1'b1 ||
                       bus_i.flush_e !== 1'b1) begin n_bad++;
            $display("FAIL il_e got=%0h%0h%0h want=111", bus_i.stall_f, bus_i.stall_d,
                     bus_i.flush_e); end
        step();
        drv_i(sub_x(5'd6, 5'd5, 5'd3));
        n_total++; if (bus_i.stall_d !== 1'b1 || bus_i.flush_d !== 1'b0) begin n_bad++;
            $display("FAIL il_m got=%0h/%0h want=1/0", bus_i.stall_d, bus_i.flush_d); end
        step();
        drv_i(sub_x(5'd6, 5'd5, 5'd3));
        n_total++; if (bus_i.stall_d !== 1'b0 || bus_i.stall_cnt !== 16'd2) begin n_bad++;
            $display("FAIL il_w got=%0h/%0d want=0/2", bus_i.stall_d, bus_i.stall_cnt); end
        step();
        drv_i(add_x(5'd0, 5'd1, 5'd2));
        n_total++; if (bus_i.fwd_a_e !== FWD_NONE || bus_i.alu_op_e !== ALU_SUB) begin n_bad++;
            $display("FAIL il_exec got=%0h/%0h want=0/1", bus_i.fwd_a_e, bus_i.alu_op_e); end
        step();
        drv_i(sub_x(5'd6, 5'd0, 5'd3));
        n_total++; if (bus_i.stall_d !== 1'b0) begin n_bad++;
            $display("FAIL il_x0 got=%0h want=0", bus_i.stall_d); end
    endtask

    task automatic test_branch();
        do_reset();
        drv_f(b_ins(5'd2, 5'd1, BR_NE));
        step();
        bus_f.zero_e = 1'b0;
        drv_f(NOP);
        n_total++; if ({bus_f.pc_src_e, bus_f.flush_d, bus_f.flush_e, bus_f.stall_d} !== 4'b1110)
            begin n_bad++;
            $display("FAIL bne_taken got=%0b want=1110",
                     {bus_f.pc_src_e, bus_f.flush_d, bus_f.flush_e, bus_f.stall_d}); end
        step();
        drv_f(NOP);
        n_total++; if (bus_f.pc_src_e !== 1'b0 || bus_f.flush_d !== 1'b0 ||
                       bus_f.flush_cnt !== 16'd1) begin n_bad++;
            $display("FAIL bne_after got=%0h/%0h/%0d want=0/0/1", bus_f.pc_src_e,
                     bus_f.flush_d, bus_f.flush_cnt); end
        drv_f(b_ins(5'd2, 5'd1, BR_GEU));
        step();
        bus_f.ltu_e = 1'b1;
        drv_f(NOP);
        n_total++; if (bus_f.pc_src_e !== 1'b0) begin n_bad++;
            $display("FAIL bgeu_lt got=%0h want=0", bus_f.pc_src_e); end
        bus_f.ltu_e = 1'b0;
        #1;
        n_total++; if (bus_f.pc_src_e !== 1'b1) begin n_bad++;
            $display("FAIL bgeu_ge got=%0h want=1", bus_f.pc_src_e); end
        step();
        drv_f(b_ins(5'd2, 5'd1, BR_EQ));
        step();
        bus_f.zero_e = 1'b1;
        drv_f(NOP);
        n_total++; if (bus_f.pc_src_e !== 1'b1) begin n_bad++;
            $display("FAIL beq_taken got=%0h want=1", bus_f.pc_src_e); end
        step();
        drv_f(b_ins(5'd2, 5'd1, 3'b010));
        step();
        bus_f.lt_e  = 1'b1;
        bus_f.ltu_e = 1'b1;
        drv_f(NOP);
        n_total++; if (bus_f.pc_src_e !== 1'b0 || bus_f.flush_cnt !== 16'd3) begin n_bad++;
            $display("FAIL br_f3_010 got=%0h/%0d want=0/3", bus_f.pc_src_e, bus_f.flush_cnt); end
    endtask

    task automatic test_jal_vs_stall();
        do_reset();
        drv_i(lw_x(5'd5));
        step();
        drv_i({20'h00800, 5'd1, 7'b1101111});
        n_total++; if (bus_i.stall_d !== 1'b0 || bus_i.imm_src_d !== IMM_J) begin n_bad++;
            $display("FAIL jal_dec got=%0h/%0h want=0/3", bus_i.stall_d, bus_i.imm_src_d); end
        step();
        drv_i(add_x(5'd6, 5'd5, 5'd5));
        n_total++; if ({bus_i.pc_src_e, bus_i.flush_d, bus_i.flush_e, bus_i.stall_f,
                        bus_i.stall_d} !== 5'b11100) begin n_bad++;
            $display("FAIL jal_prio got=%0b want=11100", {bus_i.pc_src_e, bus_i.flush_d,
                     bus_i.flush_e, bus_i.stall_f, bus_i.stall_d}); end
        step();
        drv_i(NOP);
        n_total++; if (bus_i.stall_cnt !== 16'd0 || bus_i.flush_cnt !== 16'd1) begin n_bad++;
            $display("FAIL jal_cnt got=%0d/%0d want=0/1", bus_i.stall_cnt, bus_i.flush_cnt); end
    endtask

    task automatic test_store();
        do_reset();
        drv_f({7'b0, 5'd2, 5'd1, 3'b001, 5'd4, 7'b0100011});
        n_total++; if (bus_f.imm_src_d !== IMM_S) begin n_bad++;
            $display("FAIL sh_imm got=%0h want=1", bus_f.imm_src_d); end
        step();
        drv_f(NOP);
        step();
        n_total++; if (bus_f.mem_write_m !== 1'b1 || bus_f.funct3_m !== 3'b001 ||
                       bus_f.reg_write_m !== 1'b0) begin n_bad++;
            $display("FAIL sh_mem got=%0h/%0h/%0h want=1/1/0", bus_f.mem_write_m,
                     bus_f.funct3_m, bus_f.reg_write_m); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drv_f(lw_x(5'd5));
        step();
        drv_f(add_x(5'd6, 5'd5, 5'd5));
        n_total++; if (bus_f.stall_d !== 1'b1) begin n_bad++;
            $display("FAIL rms_pre got=%0h want=1", bus_f.stall_d); end
        rst           = 1'b1;
        bus_f.instr_d = NOP;
        step();
        rst = 1'b0;
        #1;
        n_total++; if (bus_f.reg_write_m !== 1'b0 || bus_f.result_src_e !== 2'b00 ||
                       bus_f.stall_d !== 1'b0 || bus_f.stall_cnt !== 16'd0) begin n_bad++;
            $display("FAIL rms_post got=%0h/%0h/%0h/%0d want=0/0/0/0", bus_f.reg_write_m,
                     bus_f.result_src_e, bus_f.stall_d, bus_f.stall_cnt); end
    endtask

    task automatic test_lui();
        do_reset();
        drv_f(lw_x(5'd7));
        step();
        drv_f({20'h00038, 5'd7, 7'b0110111});
        n_total++; if (bus_f.stall_d !== 1'b0 || bus_f.imm_src_d !== IMM_U) begin n_bad++;
            $display("FAIL lui_nostall got=%0h/%0h want=0/4", bus_f.stall_d, bus_f.imm_src_d); end
        drv_f(i_ins(12'd1, 5'd7, 3'b000, 5'd8, 7'b0010011));
        n_total++; if (bus_f.stall_d !== 1'b1) begin n_bad++;
            $display("FAIL addi_stall got=%0h want=1", bus_f.stall_d); end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_interlock();
        test_branch();
        test_jal_vs_stall();
        test_store();
        test_reset_mid_stall();
        test_lui();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Parametrised successor to the pipelined RV32I control path. It decodes the instruction in Decode and carries control through the D/E, E/M and M/W stages. It adds a built-in hazard unit: forwarding selects, load-use stall, taken-branch flush, full B-type conditions and sub-word memory size. Two cycle counters (stall, flush) support performance checks. It sits beside the datapath and drives all of its pipeline enables, clears and mux selects.

## Interface
- REG_ADDR_W, 5, register index width (4 for RV32E)
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall-only interlock mode
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- instr_d  in  32  instruction in Decode
- zero_e, lt_e, ltu_e  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- imm_src_d  out  3  immediate format select
- alu_src_a_e, alu_src_b_e  out  1 each  ALU operand selects
- alu_op_e  out  alu_op_t  ALU operation
- result_src_e, result_src_w  out  2 each  result select: 00 ALU, 01 memory, 10 PC+4
- mem_write_m  out  1  data memory write enable
- funct3_m  out  3  load/store size and sign
- reg_write_m, reg_write_w  out  1 each  register write enables
- pc_src_e  out  1  take branch/jump target
- stall_f, stall_d  out  1 each  hold PC and F/D register
- flush_d, flush_e  out  1 each  clear F/D and D/E registers
- fwd_a_e, fwd_b_e  out  fwd_sel_t  forwarding selects: 00 register file, 01 writeback, 10 memory stage
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Decode is combinational from instr_d. uses_rs1 is 0 for LUI, AUIPC and JAL. uses_rs2 is 1 only for R-type, store and branch.
- rd, rs1, rs2 and funct3 are pipelined internally alongside the control bits.
- Branch condition, from funct3_e:
  - 000: zero_e
  - 001: !zero_e
  - 100: lt_e
  - 101: !lt_e
  - 110: ltu_e
  - 111: !ltu_e
  - any other value: 0
- pc_src_e = jump_e | (branch_e & cond).
- Forwarding, FWD_EN=1, evaluated per operand:
  - 10 if reg_write_m, rd_m≠0 and rd_m==rs_e;
  - else 01 if reg_write_w, rd_w≠0 and rd_w==rs_e;
  - else 00.
- Forwarding, FWD_EN=0: fwd_*_e is held at 00.
- Load-use hazard, FWD_EN=1: result_src_e==01, rd_e≠0, and rd_e matches a used rs of Decode. Response: stall_f=stall_d=flush_e=1.
- Interlock, FWD_EN=0: hazard when a used rs of Decode matches rd_e or rd_m, that stage has reg_write set, and rd≠0. Same response. The register file writes before it reads, so writeback is never a hazard.
- Taken branch/jump (pc_src_e=1): flush_d=flush_e=1.
- Flush has priority over stall: when both occur in one cycle, stall_f=stall_d=0.
- A bubble clears reg_write, mem_write, branch and jump; all other fields are don't-care.
- stall_cnt increments on every cycle with stall_d=1. flush_cnt increments on every cycle with pc_src_e=1. Both wrap modulo 2^CNT_W.

## Timing
- Reset clears every pipeline register to a bubble and both counters to 0. In the cycle after reset, every registered output is 0, stall/flush are 0 and fwd selects are 00.
- Registered outputs: E/M/W stage fields and the counters.
- Combinational outputs, valid in the same cycle: imm_src_d, pc_src_e, stall_*, flush_*, fwd_*.
- flush_e and rst both clear the D/E register on the next edge; rst wins.
- Stall duration:
  - load-use, FWD_EN=1: exactly 1 cycle;
  - FWD_EN=0, producer in E: 2 cycles;
  - FWD_EN=0, producer in M: 1 cycle.
- Taken-branch penalty: 2 cycles.
- Counters update on the same edge as the pipeline registers.
- rst asserted mid-stall or mid-flush has effect on the next edge; no partial state survives.

## Structure
- Add to package types:
  - fwd_sel_t (FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - result-source constants RES_ALU, RES_MEM, RES_PC4;
  - branch funct3 constants BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU.
- Reuse the existing main decoder and ALU decoder unchanged.
- The extended stage registers are local to this block.
- One sub-module: hazard_unit. It is purely combinational and takes FWD_EN and REG_ADDR_W, rd/rs fields, reg_write and result_src. It outputs stalls, flushes and forwarding selects.

## Test plan
- FWD_EN=1: add x5,x1,x2 then sub x6,x5,x3. With sub in E → fwd_a_e=10, no stall. With one NOP between them → fwd_a_e=01.
- FWD_EN=1: lw x5,0(x0) then add x6,x5,x5 → stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_a_e=fwd_b_e=01; stall_cnt=1.
- FWD_EN=0: same add/sub pair → 2 stall cycles, then proceed with fwd selects at 00. A producer to x0 → no stall.
- bne with zero_e=0 → pc_src_e=1, flush_d=flush_e=1 for 1 cycle, flush_cnt=1. bgeu with ltu_e=1 → pc_src_e=0.
- Load-use hazard coinciding with a taken jal in E → flush_d=flush_e=1, stall_f=stall_d=0, stall_cnt unchanged.
- rst asserted during a stall → next cycle all outputs 0 and counters 0. lui x7 following lw x7 → no stall (rs unused).
